// File: rtl/nes_loader_if.sv
// Command bus between the loader and the NES block: {opcode, byte} writes,
// target address, and the CPU data-out coming back.
interface nes_loader_if;
    logic        chipselect;
    logic        write;
    logic [15:0] writedata;
    logic [15:0] address;
    logic [7:0]  readdata;

    modport master (
        output chipselect,
        output write,
        output writedata,
        output address,
        input  readdata
    );

    modport slave (
        input  chipselect,
        input  write,
        input  writedata,
        input  address,
        output readdata
    );
endinterface

// File: rtl/nes_loader.sv
// Resets the NES CPU, streams a program image into its memory over the
// command bus, then launches it and relays pause and CPU data-out.
module nes_loader #(
    parameter int RESET_CYCLES = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [15:0]  base_addr,
    input  logic [15:0]  length,
    input  logic [7:0]   s_data,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic         pause,
    input  logic         abort,
    nes_loader_if.master bus,
    output logic [7:0]   cpu_dout,
    output logic         busy,
    output logic         done
);

    localparam logic [7:0] RESET_CPU = 8'd0;
    localparam logic [7:0] START_CPU = 8'd1;
    localparam logic [7:0] PAUSE_CPU = 8'd2;
    localparam logic [7:0] WRITE_MEM = 8'd3;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_RESET  = 3'd1;
    localparam logic [2:0] ST_LOAD   = 3'd2;
    localparam logic [2:0] ST_LAUNCH = 3'd3;
    localparam logic [2:0] ST_RUN    = 3'd4;

    localparam logic [7:0] RST_LAST = 8'(RESET_CYCLES - 1);

    logic [2:0]  state_reg, state_next;
    logic [7:0]  rst_cnt_reg, rst_cnt_next;
    logic [15:0] remain_reg, remain_next;
    logic [15:0] cur_addr_reg, cur_addr_next;
    logic [15:0] wd_reg, wd_next;
    logic [15:0] addr_reg, addr_next;
    logic        cs_reg, cs_next;
    logic        wr_reg, wr_next;
    logic        done_reg, done_next;
    logic [7:0]  dout_reg, dout_next;

    // s_ready drops once the last byte is taken; LOAD then spends one more
    // cycle while that final write is on the bus before launching.
    assign s_ready = (state_reg == ST_LOAD) && (remain_reg != 16'd0);
    assign busy    = (state_reg == ST_RESET) || (state_reg == ST_LOAD) ||
                     (state_reg == ST_LAUNCH);
    assign done    = done_reg;
    assign cpu_dout = dout_reg;

    assign bus.chipselect = cs_reg;
    assign bus.write      = wr_reg;
    assign bus.writedata  = wd_reg;
    assign bus.address    = addr_reg;

    always_comb begin
        state_next    = state_reg;
        rst_cnt_next  = rst_cnt_reg;
        remain_next   = remain_reg;
        cur_addr_next = cur_addr_reg;
        wd_next       = wd_reg;
        addr_next     = addr_reg;
        cs_next       = cs_reg;
        wr_next       = wr_reg;
        done_next     = 1'b0;
        dout_next     = dout_reg;

        if (state_reg == ST_RUN) begin
            dout_next = bus.readdata;
        end

        case (state_reg)
            ST_IDLE, ST_RUN: begin
                if (start) begin
                    state_next    = ST_RESET;
                    rst_cnt_next  = RST_LAST;
                    remain_next   = length;
                    cur_addr_next = base_addr;
                    wd_next       = {RESET_CPU, 8'h00};
                    cs_next       = 1'b1;
                    wr_next       = 1'b1;
                end else if (state_reg == ST_IDLE) begin
                    wd_next = {PAUSE_CPU, 8'h00};
                    cs_next = 1'b0;
                    wr_next = 1'b0;
                end else begin
                    wd_next = {(pause ? PAUSE_CPU : START_CPU), 8'h00};
                    cs_next = 1'b1;
                    wr_next = 1'b0;
                end
            end
            ST_RESET: begin
                if (rst_cnt_reg == 8'd0) begin
                    if (remain_reg != 16'd0) begin
                        state_next = ST_LOAD;
                        wd_next    = {PAUSE_CPU, 8'h00};
                        cs_next    = 1'b1;
                        wr_next    = 1'b0;
                    end else begin
                        state_next = ST_LAUNCH;
                        wd_next    = {START_CPU, 8'h00};
                        cs_next    = 1'b1;
                        wr_next    = 1'b1;
                        done_next  = 1'b1;
                    end
                end else begin
                    rst_cnt_next = rst_cnt_reg - 8'd1;
                end
            end
            ST_LOAD: begin
                if (remain_reg == 16'd0) begin
                    state_next = ST_LAUNCH;
                    wd_next    = {START_CPU, 8'h00};
                    cs_next    = 1'b1;
                    wr_next    = 1'b1;
                    done_next  = 1'b1;
                end else if (s_valid) begin
                    wd_next       = {WRITE_MEM, s_data};
                    addr_next     = cur_addr_reg;
                    cs_next       = 1'b1;
                    wr_next       = 1'b1;
                    cur_addr_next = cur_addr_reg + 16'd1;
                    remain_next   = remain_reg - 16'd1;
                end else begin
                    // Stall: park the bus on PAUSE so the last byte is not rewritten.
                    wd_next = {PAUSE_CPU, 8'h00};
                    cs_next = 1'b1;
                    wr_next = 1'b0;
                end
            end
            ST_LAUNCH: begin
                state_next = ST_RUN;
                wd_next    = {(pause ? PAUSE_CPU : START_CPU), 8'h00};
                cs_next    = 1'b1;
                wr_next    = 1'b0;
            end
            default: begin
                state_next = ST_IDLE;
                wd_next    = {PAUSE_CPU, 8'h00};
                cs_next    = 1'b0;
                wr_next    = 1'b0;
            end
        endcase

        // abort overrides every transition above, including a same-cycle start.
        if (abort) begin
            state_next   = ST_IDLE;
            rst_cnt_next = 8'd0;
            remain_next  = 16'd0;
            wd_next      = {PAUSE_CPU, 8'h00};
            addr_next    = 16'd0;
            cs_next      = 1'b0;
            wr_next      = 1'b0;
            done_next    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= ST_IDLE;
            rst_cnt_reg  <= 8'd0;
            remain_reg   <= 16'd0;
            cur_addr_reg <= 16'd0;
            wd_reg       <= {PAUSE_CPU, 8'h00};
            addr_reg     <= 16'd0;
            cs_reg       <= 1'b0;
            wr_reg       <= 1'b0;
            done_reg     <= 1'b0;
            dout_reg     <= 8'h00;
        end else begin
            state_reg    <= state_next;
            rst_cnt_reg  <= rst_cnt_next;
            remain_reg   <= remain_next;
            cur_addr_reg <= cur_addr_next;
            wd_reg       <= wd_next;
            addr_reg     <= addr_next;
            cs_reg       <= cs_next;
            wr_reg       <= wr_next;
            done_reg     <= done_next;
            dout_reg     <= dout_next;
        end
    end

endmodule

// File: doc/nes_loader.md
NES_LOADER -- requirements
Module: nes_loader

Interface
REQ-001 SHALL have parameter RESET_CYCLES, default 4, meaning the number of consecutive cycles RESET_CPU is driven (legal range 1..255).
REQ-002 SHALL have opcode constants RESET_CPU=8'd0, START_CPU=8'd1, PAUSE_CPU=8'd2, WRITE_MEM=8'd3, carried in writedata[15:8].
REQ-003 Port clk  in  1  sole clock; all state updates on posedge.
REQ-004 Port reset_n  in  1  asynchronous, active-low reset.
REQ-005 Port start  in  1  pulse; begins a reset/load/launch sequence.
REQ-006 Port base_addr  in  16  first load address; sampled when start is accepted.
REQ-007 Port length  in  16  byte count to load; sampled when start is accepted; 0 = no load.
REQ-008 Port s_data  in  8  load byte stream data.
REQ-009 Port s_valid  in  1  s_data valid.
REQ-010 Port s_ready  out  1  loader accepts s_data this cycle.
REQ-011 Port pause  in  1  level; in RUN, holds the NES CPU paused.
REQ-012 Port abort  in  1  pulse; returns to IDLE from any state.
REQ-013 Port chipselect  out  1  command bus select.
REQ-014 Port write  out  1  command bus write strobe.
REQ-015 Port writedata  out  16  {opcode, data byte}.
REQ-016 Port address  out  16  memory address for WRITE_MEM.
REQ-017 Port readdata  in  8  CPU data-out returned by the NES block.
REQ-018 Port cpu_dout  out  8  registered copy of readdata.
REQ-019 Port busy  out  1  high in every state except IDLE and RUN.
REQ-020 Port done  out  1  one-cycle pulse on entry to RUN.

Function
REQ-021 SHALL register all command-bus outputs; writedata always carries a defined opcode, because the NES block decodes writedata[15:8] every cycle regardless of chipselect.
REQ-022 SHALL implement FSM states IDLE, RESET, LOAD, LAUNCH, RUN.
REQ-023 IDLE: writedata={PAUSE_CPU,8'h00}, chipselect=0, write=0; start -> RESET.
REQ-024 Start accepted at cycle t (IDLE or RUN) -> writedata={RESET_CPU,8'h00}, chipselect=1, write=1 during cycles t+1..t+RESET_CYCLES.
REQ-025 RESET: after RESET_CYCLES cycles, go to LOAD if the latched length>0, otherwise to LAUNCH.
REQ-026 LOAD: s_ready=1 while remaining count>0; s_ready=0 in all other states.
REQ-027 Byte accepted at cycle t (s_valid and s_ready) -> at t+1, writedata={WRITE_MEM,s_data}, address=current address, chipselect=1, write=1; current address +1; remaining count -1.
REQ-028 LOAD stall cycle (s_valid=0) -> next cycle writedata={PAUSE_CPU,8'h00}, write=0, so no byte is written twice.
REQ-029 Address SHALL wrap 16'hFFFF -> 16'h0000 with no error.
REQ-030 When the last byte is accepted, s_ready SHALL go low the next cycle; state -> LAUNCH.
REQ-031 LAUNCH: one cycle of writedata={START_CPU,8'h00}, chipselect=1, write=1; done=1 that cycle; -> RUN.
REQ-032 RUN: writedata={START_CPU,8'h00} when pause=0 and {PAUSE_CPU,8'h00} when pause=1, with output lagging pause by one cycle; chipselect=1, write=0.
REQ-033 RUN: cpu_dout <= readdata every cycle; cpu_dout holds its value in all other states.
REQ-034 start in RESET, LOAD or LAUNCH SHALL be ignored.
REQ-035 abort has priority over start and over all other state transitions; the next cycle is IDLE with IDLE outputs; any in-flight load is discarded.
REQ-036 start and abort in the same cycle -> abort wins.

Reset
REQ-037 Asynchronous assertion of reset_n=0 SHALL force IDLE, writedata=16'h0200, address=0, chipselect=0, write=0, s_ready=0, busy=0, done=0, cpu_dout=0, counters=0, including mid-LOAD.
REQ-038 The first start SHALL be accepted no earlier than the first posedge after reset_n deasserts.

Verification
REQ-039 Start with base_addr=16'h8000, length=3, bytes A9 01 EA streamed without gaps -> 4 cycles of 16'h0000, then writes 03A9@8000, 0301@8001, 03EA@8002, then one 0100 cycle with done=1, then RUN.
REQ-040 Same load with s_valid low for 2 cycles between bytes -> two 0200 cycles with write=0; each address written exactly once.
REQ-041 base_addr=16'hFFFF, length=2 -> writes at FFFF then 0000.
REQ-042 length=0 -> RESET followed directly by LAUNCH; s_ready never asserts.
REQ-043 In RUN, toggle pause and drive readdata=8'h5A -> writedata alternates 0200/0100 one cycle after each pause change; cpu_dout=8'h5A.
REQ-044 Assert abort mid-LOAD, and separately assert reset_n=0 mid-LOAD -> IDLE outputs, 16'h0200 on writedata; a new start reloads from base_addr.
